// File: rtl/dense_layer_mac_if.sv
// Handshake and data bus for dense_layer_mac: frame control, pixel stream, weight ROM port and results.
// The slave modport is the engine side; the master modport is the surrounding system (source, ROM, sink).
interface dense_layer_mac_if #(
    parameter int N_OUT      = 10,
    parameter int PIX_WIDTH  = 8,
    parameter int W_WIDTH    = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int IDX_WIDTH  = 4
);
    logic                       start;
    logic                       busy;
    logic                       pixel_valid;
    logic                       pixel_ready;
    logic [PIX_WIDTH-1:0]       pixel_in;
    logic [ADDR_WIDTH-1:0]      rom_addr;
    logic [N_OUT*W_WIDTH-1:0]   rom_q;
    logic [N_OUT*ACC_WIDTH-1:0] acc_out;
    logic                       result_valid;
    logic [IDX_WIDTH-1:0]       class_idx;

    modport master (
        output start, pixel_valid, pixel_in, rom_q,
        input  busy, pixel_ready, rom_addr, acc_out, result_valid, class_idx
    );

    modport slave (
        input  start, pixel_valid, pixel_in, rom_q,
        output busy, pixel_ready, rom_addr, acc_out, result_valid, class_idx
    );
endinterface

// File: rtl/dense_layer_mac.sv
// Streaming fully-connected layer: one unsigned pixel per cycle times a ROM weight row into N_OUT
// saturating signed accumulators. Define ARGMAX_EN to build the sequential argmax SCAN stage.
module dense_layer_mac #(
    parameter int N_IN       = 784,
    parameter int N_OUT      = 10,
    parameter int PIX_WIDTH  = 8,
    parameter int W_WIDTH    = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int IDX_WIDTH  = 4
) (
    input  logic             pclk,
    input  logic             rst,
    dense_layer_mac_if.slave bus
);
    localparam int PROD_W = PIX_WIDTH + W_WIDTH + 1;
    localparam int SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;
    localparam logic signed [SUM_W-1:0] ACC_MAX =
        {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN =
        {{(SUM_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
`ifdef ARGMAX_EN
        SCAN,
`endif
        DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [ADDR_WIDTH-1:0]       cnt_q;
    logic [PIX_WIDTH-1:0]        pixel_r;
    logic                        vld_q;
    logic signed [ACC_WIDTH-1:0] acc_q [N_OUT];
    logic signed [ACC_WIDTH-1:0] acc_d [N_OUT];
    logic signed [PROD_W-1:0]    prod  [N_OUT];
    logic signed [SUM_W-1:0]     sum   [N_OUT];
    logic                        accept;
    logic                        last_accept;
    logic                        frame_start;

`ifdef ARGMAX_EN
    logic [IDX_WIDTH-1:0]        scan_q;
    logic [IDX_WIDTH-1:0]        best_idx_q;
    logic signed [ACC_WIDTH-1:0] best_q;
`endif

    assign frame_start = (state_q == IDLE) && bus.start;
    assign accept      = (state_q == MAC) && bus.pixel_valid;
    assign last_accept = accept && (cnt_q == ADDR_WIDTH'(N_IN - 1));

    assign bus.busy         = (state_q != IDLE);
    assign bus.pixel_ready  = (state_q == MAC);
    assign bus.result_valid = (state_q == DONE);
    assign bus.rom_addr     = cnt_q;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start) state_d = MAC;
            MAC:   if (last_accept) state_d = DRAIN;
`ifdef ARGMAX_EN
            DRAIN: state_d = SCAN;
            SCAN:  if (scan_q == IDX_WIDTH'(N_OUT - 1)) state_d = DONE;
`else
            DRAIN: state_d = DONE;
`endif
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pixel is zero-extended, weight sign-extended, both to the full product width; the sum carries
    // one guard bit so the clamp sees the true result before it is narrowed back to ACC_WIDTH.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            prod[j] = $signed({{(W_WIDTH+1){1'b0}}, pixel_r})
                    * $signed({{(PIX_WIDTH+1){bus.rom_q[j*W_WIDTH+W_WIDTH-1]}},
                               bus.rom_q[j*W_WIDTH +: W_WIDTH]});
            sum[j]  = {{(SUM_W-ACC_WIDTH){acc_q[j][ACC_WIDTH-1]}}, acc_q[j]}
                    + {{(SUM_W-PROD_W){prod[j][PROD_W-1]}}, prod[j]};
            if (sum[j] > ACC_MAX) begin
                acc_d[j] = ACC_MAX[ACC_WIDTH-1:0];
            end else if (sum[j] < ACC_MIN) begin
                acc_d[j] = ACC_MIN[ACC_WIDTH-1:0];
            end else begin
                acc_d[j] = sum[j][ACC_WIDTH-1:0];
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the accumulator bank is reset because acc_out must read zero straight out of reset.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            pixel_r <= '0;
            vld_q   <= 1'b0;
            for (int j = 0; j < N_OUT; j++) acc_q[j] <= '0;
        end else begin
            vld_q <= accept;
            if (accept) begin
                pixel_r <= bus.pixel_in;
                cnt_q   <= last_accept ? '0 : cnt_q + 1'b1;
            end
            if (frame_start) begin
                cnt_q <= '0;
                for (int j = 0; j < N_OUT; j++) acc_q[j] <= '0;
            end else if (vld_q) begin
                for (int j = 0; j < N_OUT; j++) acc_q[j] <= acc_d[j];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            bus.acc_out[j*ACC_WIDTH +: ACC_WIDTH] = acc_q[j];
        end
    end

`ifdef ARGMAX_EN
    // Running best starts at the most negative value, so channel 0 always seeds the index and
    // only a strictly greater value can displace an earlier channel.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            scan_q     <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
        end else if (frame_start) begin
            best_idx_q <= '0;
        end else if (state_q == DRAIN) begin
            scan_q     <= '0;
            best_idx_q <= '0;
            best_q     <= ACC_MIN[ACC_WIDTH-1:0];
        end else if (state_q == SCAN) begin
            scan_q <= scan_q + 1'b1;
            if (acc_q[scan_q] > best_q) begin
                best_q     <= acc_q[scan_q];
                best_idx_q <= scan_q;
            end
        end
    end

    assign bus.class_idx = best_idx_q;
`else
    assign bus.class_idx = '0;
`endif
endmodule

// File: tb/tb_dense_layer_mac.sv
// Self-checking bench for dense_layer_mac: a 32-bit and a 16-bit accumulator instance share one
// stimulus stream and are compared against a saturating dot-product model. Honours ARGMAX_EN.
module tb_dense_layer_mac;
    localparam int N_IN  = 784;
    localparam int N_OUT = 10;
`ifdef ARGMAX_EN
    localparam int EXP_LAT = N_OUT + 1;
    localparam bit ARGMAX  = 1'b1;
`else
    localparam int EXP_LAT = 1;
    localparam bit ARGMAX  = 1'b0;
`endif

    logic       pclk;
    logic       rst;
    logic       start;
    logic       pixel_valid;
    logic [7:0] pixel_in;

    logic signed [7:0] w_tab   [N_IN][N_OUT];
    logic        [7:0] pix_tab [N_IN];
    longint            exp_acc [2][N_OUT];
    longint            exp_cls [2];

    int total = 0;
    int bad   = 0;

    dense_layer_mac_if #(.ACC_WIDTH(32)) bif_a ();
    dense_layer_mac_if #(.ACC_WIDTH(16)) bif_b ();

    dense_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_WIDTH(32)) dut_a (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bif_a)
    );

    dense_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_WIDTH(16)) dut_b (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bif_b)
    );

    assign bif_a.start       = start;
    assign bif_a.pixel_valid = pixel_valid;
    assign bif_a.pixel_in    = pixel_in;
    assign bif_b.start       = start;
    assign bif_b.pixel_valid = pixel_valid;
    assign bif_b.pixel_in    = pixel_in;

    logic   busy_s [2];
    logic   rdy_s  [2];
    logic   rv_s   [2];
    longint addr_s [2];
    longint cls_s  [2];
    longint acc_s  [2][N_OUT];

    always_comb begin
        busy_s[0] = bif_a.busy;         busy_s[1] = bif_b.busy;
        rdy_s[0]  = bif_a.pixel_ready;  rdy_s[1]  = bif_b.pixel_ready;
        rv_s[0]   = bif_a.result_valid; rv_s[1]   = bif_b.result_valid;
        addr_s[0] = longint'(bif_a.rom_addr);
        addr_s[1] = longint'(bif_b.rom_addr);
        cls_s[0]  = longint'(bif_a.class_idx);
        cls_s[1]  = longint'(bif_b.class_idx);
        for (int j = 0; j < N_OUT; j++) begin
            acc_s[0][j] = longint'($signed(bif_a.acc_out[j*32 +: 32]));
            acc_s[1][j] = longint'($signed(bif_b.acc_out[j*16 +: 16]));
        end
    end

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic logic [N_OUT*8-1:0] rom_row(input logic [9:0] addr);
        logic [N_OUT*8-1:0] r;
        r = '0;
        if (int'(addr) < N_IN) begin
            for (int j = 0; j < N_OUT; j++) r[j*8 +: 8] = w_tab[addr][j];
        end
        return r;
    endfunction

    // Synchronous weight ROM with one cycle of read latency, one per instance
    always @(posedge pclk) begin
        bif_a.rom_q <= rom_row(bif_a.rom_addr);
        bif_b.rom_q <= rom_row(bif_b.rom_addr);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Mode 0 basic ramp, 1 signed (-1 on ch3), 2 all +127, 3 all -128, 4 random
    task automatic set_tables(input int mode);
        for (int i = 0; i < N_IN; i++) begin
            case (mode)
                0:       pix_tab[i] = 8'd1;
                4:       pix_tab[i] = 8'($urandom);
                default: pix_tab[i] = 8'd255;
            endcase
            for (int j = 0; j < N_OUT; j++) begin
                case (mode)
                    0:       w_tab[i][j] = 8'(j);
                    1:       w_tab[i][j] = (j == 3) ? -8'sd1 : 8'sd1;
                    2:       w_tab[i][j] = 8'sd127;
                    3:       w_tab[i][j] = -8'sd128;
                    default: w_tab[i][j] = 8'($urandom);
                endcase
            end
        end
    endtask

    task automatic compute_model();
        int widths [2];
        widths[0] = 32;
        widths[1] = 16;
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < N_OUT; j++) exp_acc[d][j] = 0;
            for (int i = 0; i < N_IN; i++) begin
                for (int j = 0; j < N_OUT; j++) begin
                    exp_acc[d][j] = sat(exp_acc[d][j]
                                  + longint'(pix_tab[i]) * longint'(w_tab[i][j]), widths[d]);
                end
            end
            exp_cls[d] = 0;
            if (ARGMAX) begin
                for (int j = 1; j < N_OUT; j++) begin
                    if (exp_acc[d][j] > exp_acc[d][exp_cls[d]]) exp_cls[d] = j;
                end
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        for (int d = 0; d < 2; d++) begin
            int nz = 0;
            for (int j = 0; j < N_OUT; j++) if (acc_s[d][j] != 0) nz++;
            check($sformatf("%s_busy_d%0d", tag, d), longint'(busy_s[d]), 0);
            check($sformatf("%s_ready_d%0d", tag, d), longint'(rdy_s[d]), 0);
            check($sformatf("%s_addr_d%0d", tag, d), addr_s[d], 0);
            check($sformatf("%s_rv_d%0d", tag, d), longint'(rv_s[d]), 0);
            check($sformatf("%s_cls_d%0d", tag, d), cls_s[d], 0);
            check($sformatf("%s_acc_nz_d%0d", tag, d), nz, 0);
        end
    endtask

    task automatic check_results(input string tag);
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < N_OUT; j++) begin
                check($sformatf("%s_acc%0d_d%0d", tag, j, d), acc_s[d][j], exp_acc[d][j]);
            end
            check($sformatf("%s_cls_d%0d", tag, d), cls_s[d], exp_cls[d]);
        end
    endtask

    // Runs one frame from IDLE. abort_at/start_at < 0 disable those events.
    task automatic run_frame(input string tag, input int pct, input int abort_at,
                             input int start_at, input bit start_in_done, input bit quick);
        int k, iter, n, rdy_err, rv_err;
        int lat [2];
        int pulses [2];
        bit stop;
        compute_model();
        @(negedge pclk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_idle_ready_d%0d", tag, d), longint'(rdy_s[d]), 0);
            check($sformatf("%s_idle_rv_d%0d", tag, d), longint'(rv_s[d]), 0);
        end
        start       = 1'b1;
        pixel_valid = 1'b1;
        pixel_in    = 8'($urandom);
        @(negedge pclk);
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_busy_d%0d", tag, d), longint'(busy_s[d]), 1);
        end

        k = 0; iter = 0; rdy_err = 0;
        while (k < N_IN && iter < 20 * N_IN) begin
            if (k == abort_at) begin
                pixel_valid = 1'b0;
                rst = 1'b0;
                #1;
                check_cleared({tag, "_abort"});
                rv_err = 0;
                repeat (3) begin
                    @(negedge pclk);
                    for (int d = 0; d < 2; d++) if (rv_s[d] !== 1'b0) rv_err++;
                end
                check({tag, "_abort_no_rv"}, rv_err, 0);
                rst = 1'b1;
                return;
            end
            pixel_valid = ($urandom_range(0, 99) < pct);
            pixel_in    = pixel_valid ? pix_tab[k] : 8'($urandom);
            start       = (k == start_at);
            for (int d = 0; d < 2; d++) if (rdy_s[d] !== 1'b1) rdy_err++;
            @(posedge pclk);
            if (pixel_valid) k++;
            iter++;
            @(negedge pclk);
        end
        start = 1'b0;
        check({tag, "_mac_budget"}, k, N_IN);
        check({tag, "_ready_mac"}, rdy_err, 0);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_drain_ready_d%0d", tag, d), longint'(rdy_s[d]), 0);
        end

        // Keep pixel_valid high after the frame: it must have no effect outside MAC
        pixel_valid = 1'b1;
        n = 0; stop = 1'b0;
        lat = '{-1, -1};
        pulses = '{0, 0};
        while (n < N_OUT + 6 && !stop) begin
            @(posedge pclk);
            n++;
            @(negedge pclk);
            start    = 1'b0;
            pixel_in = 8'($urandom);
            for (int d = 0; d < 2; d++) begin
                if (rv_s[d] === 1'b1) begin
                    pulses[d]++;
                    if (lat[d] < 0) begin
                        lat[d] = n;
                        check($sformatf("%s_done_ready_d%0d", tag, d), longint'(rdy_s[d]), 0);
                        check($sformatf("%s_done_busy_d%0d", tag, d), longint'(busy_s[d]), 1);
                    end
                end
            end
            if (rv_s[0] === 1'b1 || rv_s[1] === 1'b1) begin
                check_results(tag);
                if (start_in_done) start = 1'b1;
                if (quick) stop = 1'b1;
            end
        end
        start       = 1'b0;
        pixel_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_latency_d%0d", tag, d), lat[d], EXP_LAT);
            if (!quick) begin
                check($sformatf("%s_rv_pulses_d%0d", tag, d), pulses[d], 1);
                check($sformatf("%s_post_busy_d%0d", tag, d), longint'(busy_s[d]), 0);
            end
        end
        if (!quick) check_results({tag, "_hold"});
    endtask

    initial begin
        start       = 1'b0;
        pixel_valid = 1'b0;
        pixel_in    = '0;
        rst         = 1'b1;
        set_tables(0);
        #2 rst = 1'b0;
        repeat (3) @(negedge pclk);
        check_cleared("reset");
        rst = 1'b1;

        set_tables(0); run_frame("basic",   100, -1, -1, 1'b0, 1'b0);
        set_tables(1); run_frame("signed",  100, -1, -1, 1'b0, 1'b0);
        set_tables(2); run_frame("sat_pos", 100, -1, -1, 1'b0, 1'b0);
        set_tables(3); run_frame("sat_neg", 100, -1, -1, 1'b0, 1'b0);
        set_tables(0); run_frame("bp50",     50, -1, -1, 1'b0, 1'b0);
        set_tables(0); run_frame("abort",   100, 400, -1, 1'b0, 1'b0);
        set_tables(0); run_frame("post_abort", 70, -1, -1, 1'b0, 1'b0);
        set_tables(4); run_frame("start_busy", 80, -1, 100, 1'b0, 1'b0);
        set_tables(4); run_frame("start_done", 100, -1, -1, 1'b1, 1'b0);
        set_tables(4); run_frame("b2b_first", 90, -1, -1, 1'b0, 1'b1);
        set_tables(4); run_frame("b2b_second", 60, -1, -1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dense_layer_mac.md
# dense_layer_mac

Streaming fully-connected layer engine: accepts one unsigned pixel per cycle and fetches the matching weight row from an external synchronous weight ROM. It accumulates N_OUT signed dot products in parallel and reports them, plus an optional argmax class index, once the frame completes. Sits between the pixel preprocessor and the digit classifier output logic. It is the parametrised, handshaked replacement for the fixed 784×10 multiply bank.

## Interface
- N_IN, 784, pixels per frame (ROM depth)
- N_OUT, 10, output neurons / accumulator channels
- PIX_WIDTH, 8, unsigned pixel width
- W_WIDTH, 8, signed two's-complement weight width
- ACC_WIDTH, 32, signed accumulator width
- ADDR_WIDTH, 10, ROM address width, ≥ clog2(N_IN)
- IDX_WIDTH, 4, class index width, ≥ clog2(N_OUT)

Ports:
- pclk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- busy  out  1  high from start acceptance until result_valid
- pixel_valid  in  1  pixel_in is valid
- pixel_ready  out  1  engine accepts a pixel this cycle
- pixel_in  in  PIX_WIDTH  pixel value
- rom_addr  out  ADDR_WIDTH  weight-row address; ROM registers it on pclk
- rom_q  in  N_OUT*W_WIDTH  weight row, valid one cycle after address; channel j at [j*W_WIDTH +: W_WIDTH]
- acc_out  out  N_OUT*ACC_WIDTH  accumulator results, channel j at [j*ACC_WIDTH +: ACC_WIDTH]
- result_valid  out  1  one-cycle pulse: acc_out and class_idx final
- class_idx  out  IDX_WIDTH  argmax channel (ARGMAX_EN only, else 0)

## Operation
- States: IDLE, MAC, DRAIN, SCAN (ARGMAX_EN only), DONE.
- IDLE: pixel_ready=0. On start=1, clear all accumulators, clear the pixel counter, and go to MAC. busy=1 from the next cycle.
- MAC: pixel_ready=1. rom_addr = pixel counter. A pixel is accepted on a cycle with pixel_valid&pixel_ready. On acceptance:
  - the ROM latches the address;
  - pixel_in is registered;
  - a valid flag is set;
  - the counter increments.
- Accumulate stage, one edge after acceptance: acc[j] += pixel_r × w[j]. pixel_r is zero-extended to a signed value. The product width is PIX_WIDTH+W_WIDTH+1 signed, sign-extended to ACC_WIDTH.
- Accumulators saturate at ±(2^(ACC_WIDTH-1)) bounds and never wrap. Once saturated, a channel stays clamped unless an opposite-sign product pulls it back.
- Gaps in pixel_valid stall the pipeline with no effect on the result.
- Acceptance of pixel N_IN-1 moves the state to DRAIN, and pixel_ready drops the same edge.
- DRAIN: lasts one cycle, completing the final accumulate. Then go to SCAN if ARGMAX_EN is defined, else to DONE.
- SCAN: N_OUT cycles, comparing channels 0..N_OUT-1 sequentially, signed. The strictly greater value wins, so ties keep the lowest index.
- DONE: result_valid=1 for one cycle, then IDLE with busy=0.
- acc_out and class_idx hold their values until the next start is accepted.
- start while busy is ignored.
- start and result_valid in the same cycle: start is ignored. A new start is accepted from IDLE only.
- pixel_valid outside MAC is ignored, with no acceptance.

## Timing
- Reset values: busy=0, pixel_ready=0, rom_addr=0, acc_out=0, result_valid=0, class_idx=0, state IDLE, counter 0, pipeline valid 0.
- Reset asserted mid-frame aborts immediately: all state clears, and no result_valid is produced.
- start edge S: MAC active from S+1, so the first acceptance is possible in the cycle after S.
- Throughput: 1 pixel/cycle. The minimum frame runs N_IN cycles in MAC.
- Last acceptance edge E:
  - accumulate at E+1;
  - without ARGMAX_EN, result_valid is high in the cycle after edge E+1;
  - with ARGMAX_EN, it is high N_OUT cycles later.
- ROM contract: exactly one cycle registered read latency. rom_addr changes only on acceptance edges.

## Configuration
- ARGMAX_EN defined:
  - the SCAN state and argmax comparator are built;
  - class_idx is valid with result_valid;
  - latency increases by N_OUT cycles.
- ARGMAX_EN undefined:
  - no SCAN state is built;
  - class_idx is tied to 0;
  - DRAIN goes directly to DONE.

## Test plan
- Basic frame (default parameters, ARGMAX_EN defined):
  - stimulus: bench ROM w[i][j]=j, all pixels=1, continuous valid;
  - required: acc_j = 784·j; class_idx=9; result_valid once, N_OUT+1 cycles after the last-accept edge.
- Signed weights: w[i][j] = −1 for j=3 and +1 otherwise, pixels=255 → acc_3 = −199920, others = +199920; class_idx=0 (tie, lowest index).
- Saturation: ACC_WIDTH=16, pixels=255, w=127 → all acc_out = 32767 with no wrap. Repeat with w=−128 → −32768.
- Backpressure: pixel_valid toggling randomly at 50%, same data as the basic frame → identical acc_out. pixel_ready is low in IDLE, DRAIN and DONE.
- Reset mid-frame: assert rst after 400 accepted pixels → all outputs return to 0 at once with no result_valid. A following full frame gives the correct sums.
- start during busy: pulse start at pixel 100 → ignored, results unchanged. Back-to-back frames with start the cycle after result_valid → the second frame's sums are independent, with accumulators cleared.
